// File: rtl/wb_ram_slave.sv
// Wishbone classic single-port RAM slave with programmable wait states,
// byte-lane writes and error termination for misaligned/out-of-window accesses.
module wb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'(1) << (ADDR_WIDTH + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  logic [31:0] mem [DEPTH];

  logic [32:0]           offset;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           lane_mask;
  logic                  mem_we;

  // 33-bit offset: an address below BASE_ADDR wraps to a value >= SPAN.
  always_comb begin
    offset    = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    addr_err  = (addr_q[1:0] != 2'b00) || (offset >= SPAN);
    word_idx  = offset[ADDR_WIDTH+1:2];
    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{sel_q[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          addr_d = wbs_addr_i;
          wdat_d = wbs_dat_i;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_HOLD;
        if (addr_err) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          if (we_q) mem_we = 1'b1;
          else      dat_d  = mem[word_idx] & lane_mask;
        end
      end
      S_HOLD: begin
        if (!wbs_stb_i || !wbs_cyc_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Memory is never cleared; reset only suppresses a commit pending in RESP.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[word_idx][8*i +: 8] <= wdat_q[8*i +: 8];
      end
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte base address, aligned to 4*2**ADDR_WIDTH.
REQ-003 Parameter WAIT_STATES, default 0, range 0-15: extra cycles inserted before the response.
REQ-004 clk_i  input  1  single clock; all logic updates on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 wbs_cyc_i  input  1  bus cycle in progress.
REQ-007 wbs_stb_i  input  1  strobe; a valid transfer is requested.
REQ-008 wbs_we_i  input  1  1 = write, 0 = read.
REQ-009 wbs_sel_i  input  4  byte-lane enables; bit i selects data bits [8i+7:8i].
REQ-010 wbs_addr_i  input  32  byte address.
REQ-011 wbs_dat_i  input  32  write data.
REQ-012 wbs_dat_o  output  32  read data; registered.
REQ-013 wbs_ack_o  output  1  normal termination; registered.
REQ-014 wbs_err_o  output  1  error termination; registered.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, RESP, HOLD.
REQ-016 In IDLE, a request SHALL be accepted on a rising edge where wbs_cyc_i=1 and wbs_stb_i=1, latching we, sel, addr and dat.
REQ-017 On accept: if WAIT_STATES=0, go to RESP; otherwise load the wait counter with WAIT_STATES and go to WAIT.
REQ-018 In WAIT, decrement the counter each cycle; when it reaches 0, go to RESP.
REQ-019 If wbs_cyc_i=0 on any edge in WAIT, go to IDLE with no ack, no err and no memory write.
REQ-020 In RESP, assert exactly one of wbs_ack_o or wbs_err_o for exactly one cycle, then go to HOLD.
REQ-021 Resulting latency: accept edge to first cycle of response = WAIT_STATES+1 cycles; 1 cycle when WAIT_STATES=0.
REQ-022 In HOLD, stay until a rising edge with wbs_stb_i=0 or wbs_cyc_i=0, then go to IDLE; a strobe held high after a response is never accepted twice.
REQ-023 Error condition: latched addr[1:0]!=0, or latched addr outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_WIDTH-1].
REQ-024 Error condition SHALL produce wbs_err_o=1 and wbs_ack_o=0, with no memory write and wbs_dat_o=0.
REQ-025 For a valid write, assert ack and commit the write on the same edge that sets wbs_ack_o; write only the lanes whose sel bit is 1.
REQ-026 A write with sel=4'b0000 SHALL be acknowledged without changing memory.
REQ-027 For a valid read, wbs_dat_o SHALL hold mem[word index] during the ack cycle, where unselected lanes read as 0.
REQ-028 wbs_dat_o SHALL be 0 in every cycle that wbs_ack_o is 0.
REQ-029 wbs_ack_o and wbs_err_o SHALL never both be 1.
REQ-030 Word index SHALL be (addr-BASE_ADDR)>>2, truncated to ADDR_WIDTH bits.

Reset
REQ-031 While rst_i=1, the FSM SHALL be IDLE, the wait counter 0, and wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted in WAIT or RESP SHALL abort the transfer: no response is issued and a pending write is not committed.

Verification
REQ-034 WAIT_STATES=0: write 32'hDEADBEEF to 0x10 with sel=4'hF, then read 0x10 -> each ack 1 cycle after accept; read returns 32'hDEADBEEF.
REQ-035 Write 32'h11223344 with sel=4'b0101 over a stored 32'hDEADBEEF -> the following read returns 32'hDE22BE44.
REQ-036 Master holds cyc/stb high for one cycle after ack -> exactly one response is issued and no second write occurs.
REQ-037 Read address 0x12 (misaligned), or read address BASE_ADDR+4*2**ADDR_WIDTH -> err for 1 cycle, ack stays 0, dat_o=0, memory unchanged.
REQ-038 WAIT_STATES=3: a read is acked 4 cycles after accept; a write with cyc dropped in WAIT gets no response and leaves memory unchanged.
REQ-039 Assert rst_i in the WAIT cycle of a write -> no ack or err, outputs 0, and a subsequent read returns the old data.
